win_wr_adr_gen: RTL and testbench

- Write-side counterpart of the window read-address counter.
- Accepts a valid/ready stream of result words and writes them into a local buffer.
- Address walk uses the same raster pattern as the read side: COLS consecutive addresses, then a jump of ROW_GAP at end of row.
- Sits between the compute datapath and the result memory. It produces wr_en/wr_adr/wr_data and reports completion of a ROWS x COLS window.

---
 rtl/win_wr_adr_gen.sv | 194 +++++++++++++++++++
 tb/tb_win_wr_adr_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_wr_adr_gen.sv
// -----------------------------------------------------------------------------
// win_wr_adr_gen
//
// Write-side raster address generator. Accepts a valid/ready stream of result
// words and writes each word into a local buffer one cycle after it is
// accepted. The address walk covers a ROWS x COLS window. It steps by +1 inside
// a row. After the last column of a row it steps by ROW_GAP instead of +1. All
// address arithmetic wraps modulo 2^ADR_W.
//
// Parameters:
//   ADR_W    write address width
//   DATA_W   data word width
//   COLS     words per row (1..16)
//   ROWS     rows per window (1..16)
//   ROW_GAP  address step applied after the last column of a row
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   start_i       begin a window (sampled only while idle)
//   base_adr_i    first write address, captured with start_i
//   in_data_i     incoming word
//   in_valid_i    in_data_i is valid
//   abort_i       (WIN_WR_ABORT_EN only) abandon the current window
//   in_ready_o    a word can be accepted this cycle (combinational)
//   wr_en_o       memory write strobe
//   wr_adr_o      memory write address
//   wr_data_o     memory write data
//   busy_o        window in progress (registered)
//   done_o        one-cycle pulse together with the final write of a window
//
// Optional feature macro: WIN_WR_ABORT_EN
//   When defined, the block has an abort_i input. Asserting abort_i while
//   writing returns the block to idle and clears the pointer and counters.
//   in_ready_o is held low in the abort cycle, so no beat is accepted in that
//   cycle. A write already pending from the previous cycle still completes.
//   No done pulse is produced.
// -----------------------------------------------------------------------------
module win_wr_adr_gen #(
  parameter int ADR_W   = 8,
  parameter int DATA_W  = 8,
  parameter int COLS    = 10,
  parameter int ROWS    = 10,
  parameter int ROW_GAP = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADR_W-1:0]  base_adr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
`ifdef WIN_WR_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [ADR_W-1:0]  wr_adr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ADR_W-1:0] ADR_GAP  = ADR_W'(ROW_GAP);
  localparam logic [ADR_W-1:0] ADR_ONE  = ADR_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ADR_W-1:0]   ptr_q, ptr_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               busy_q, busy_d;
  logic               wr_en_q, wr_en_d;
  logic [ADR_W-1:0]   wr_adr_q, wr_adr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               done_q, done_d;

  logic               abort_w;
  logic               in_ready;
  logic               accept;
  logic               last_col;
  logic               last_row;

`ifdef WIN_WR_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // Ready is driven straight from the state so the upstream can see it in
  // the same cycle. An abort masks it so that no beat is taken in that cycle.
  assign in_ready = (state_q == WRITE) && !abort_w;
  assign accept   = in_valid_i && in_ready;
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    col_d     = col_q;
    row_d     = row_q;
    wr_en_d   = accept;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    done_d    = accept && last_col && last_row;

    // The write port holds its last address/data between strobes.
    if (accept) begin
      wr_adr_d  = ptr_q;
      wr_data_d = in_data_i;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WRITE;
          ptr_d   = base_adr_i;
          col_d   = '0;
          row_d   = '0;
        end
      end

      WRITE: begin
        if (abort_w) begin
          state_d = IDLE;
          ptr_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end else if (accept) begin
          if (last_col) begin
            // Row-end step replaces the +1. With COLS=1 every beat ends here.
            ptr_d = ptr_q + ADR_GAP;
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = IDLE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            ptr_d = ptr_q + ADR_ONE;
            col_d = col_q + COL_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == WRITE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign in_ready_o = in_ready;
  assign wr_en_o    = wr_en_q;
  assign wr_adr_o   = wr_adr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_win_wr_adr_gen.sv
// -----------------------------------------------------------------------------
// Testbench for win_wr_adr_gen (COLS=10, ROWS=2, ROW_GAP=4, 8-bit address).
// A reference model computes every expected write address directly from the
// beat index: address = base + row*(COLS-1+ROW_GAP) + col, modulo 256.
// A compare process checks the DUT against this model on every falling edge.
// -----------------------------------------------------------------------------
module tb_win_wr_adr_gen;

  localparam int ADR_W   = 8;
  localparam int DATA_W  = 8;
  localparam int COLS    = 10;
  localparam int ROWS    = 2;
  localparam int ROW_GAP = 4;
  localparam int BEATS   = ROWS * COLS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADR_W-1:0]  base_adr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              abort = 1'b0;
  logic              in_ready, wr_en, busy, done;
  logic [ADR_W-1:0]  wr_adr;
  logic [DATA_W-1:0] wr_data;

  win_wr_adr_gen #(
    .ADR_W(ADR_W), .DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .ROW_GAP(ROW_GAP)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .base_adr_i (base_adr),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
`ifdef WIN_WR_ABORT_EN
    .abort_i    (abort),
`endif
    .in_ready_o (in_ready),
    .wr_en_o    (wr_en),
    .wr_adr_o   (wr_adr),
    .wr_data_o  (wr_data),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [ADR_W-1:0] adr_of(input logic [ADR_W-1:0] b, input int k);
    int r;
    int c;
    int a;
    r = k / COLS;
    c = k % COLS;
    a = int'(b) + r * (COLS - 1 + ROW_GAP) + c;
    return ADR_W'(a);
  endfunction

  bit                m_active = 1'b0;
  int                m_beats = 0;
  logic [ADR_W-1:0]  m_base = '0;
  logic              exp_wr_en = 1'b0;
  logic              exp_done = 1'b0;
  logic [ADR_W-1:0]  exp_adr = '0;
  logic [DATA_W-1:0] exp_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active  <= 1'b0;
      m_beats   <= 0;
      m_base    <= '0;
      exp_wr_en <= 1'b0;
      exp_done  <= 1'b0;
    end else begin
      exp_wr_en <= 1'b0;
      exp_done  <= 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active <= 1'b1;
          m_base   <= base_adr;
          m_beats  <= 0;
        end
      end else if (abort) begin
        m_active <= 1'b0;
      end else if (in_valid) begin
        exp_wr_en <= 1'b1;
        exp_adr   <= adr_of(m_base, m_beats);
        exp_data  <= in_data;
        m_beats   <= m_beats + 1;
        if (m_beats == BEATS - 1) begin
          exp_done <= 1'b1;
          m_active <= 1'b0;
        end
      end
    end
  end

  // ---------------- compare process + write log ----------------
  typedef struct {
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
    logic              dn;
  } wr_t;
  wr_t wlog[$];

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_active && !abort);
    chk("busy", busy, m_active);
    chk("wr_en", wr_en, exp_wr_en);
    chk("done", done, exp_done);
    if (exp_wr_en) begin
      chk("wr_adr", wr_adr, exp_adr);
      chk("wr_data", wr_data, exp_data);
    end
    if (wr_en === 1'b1) wlog.push_back('{wr_adr, wr_data, done});
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win(input logic [ADR_W-1:0] b);
    start    = 1'b1;
    base_adr = b;
    tick();
    start    = 1'b0;
    base_adr = ADR_W'($urandom);
  endtask

  // mode 0: valid every cycle, data = beat index
  // mode 1: valid every other cycle, data = beat index
  // mode 2: random valid/data, random (ignored) start pulses
  task automatic stream(input int mode);
    int n = 0;
    while (m_active && n < 400) begin
      case (mode)
        0: begin in_valid = 1'b1; in_data = DATA_W'(m_beats); end
        1: begin in_valid = (n % 2 == 0); in_data = DATA_W'(m_beats); end
        default: begin
          in_valid = 1'($urandom);
          in_data  = DATA_W'($urandom);
          start    = ($urandom_range(0, 3) == 0);
          base_adr = ADR_W'($urandom);
        end
      endcase
      tick();
      n++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("window_timeout", 32'(m_active), 0);
    tick();
  endtask

  function automatic int done_count();
    int c = 0;
    foreach (wlog[i]) if (wlog[i].dn === 1'b1) c++;
    return c;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int n;

    // Reset, then idle with in_valid asserted: nothing may be accepted.
    #3;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) tick();
    chk("idle_ready", in_ready, 0);
    chk("idle_wr_en", wr_en, 0);
    in_valid = 1'b0;

    // Model pinned to hand-computed addresses.
    chk("model_adr9", adr_of(8'd0, 9), 9);
    chk("model_adr10", adr_of(8'd0, 10), 13);
    chk("model_adr19", adr_of(8'd0, 19), 22);
    chk("model_wrap6", adr_of(8'd250, 6), 0);

    // Basic window.
    wlog.delete();
    start_win(8'd0);
    stream(0);
    chk("basic_count", wlog.size(), 20);
    chk("basic_adr0", wlog[0].adr, 0);
    chk("basic_adr9", wlog[9].adr, 9);
    chk("basic_adr10", wlog[10].adr, 13);
    chk("basic_adr19", wlog[19].adr, 22);
    chk("basic_data10", wlog[10].data, 10);
    chk("basic_done_last", wlog[19].dn, 1);
    chk("basic_done_cnt", done_count(), 1);

    // Stalled window, started immediately (back-to-back).
    wlog.delete();
    start_win(8'd0);
    stream(1);
    chk("stall_count", wlog.size(), 20);
    chk("stall_adr10", wlog[10].adr, 13);
    chk("stall_adr19", wlog[19].adr, 22);
    chk("stall_data19", wlog[19].data, 19);
    chk("stall_done_cnt", done_count(), 1);

    // Address wrap.
    wlog.delete();
    start_win(8'd250);
    stream(0);
    chk("wrap_adr0", wlog[0].adr, 250);
    chk("wrap_adr5", wlog[5].adr, 255);
    chk("wrap_adr6", wlog[6].adr, 0);
    chk("wrap_adr9", wlog[9].adr, 3);
    chk("wrap_adr10", wlog[10].adr, 7);

    // Random windows.
    repeat (4) begin
      wlog.delete();
      start_win(ADR_W'($urandom));
      stream(2);
      chk("rand_count", wlog.size(), 20);
      chk("rand_done_cnt", done_count(), 1);
    end

    // Reset in the middle of a window, with a write pending.
    start_win(8'd100);
    n = 0;
    while (m_beats < 5 && n < 50) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      tick();
      n++;
    end
    chk("mid_reach5", m_beats, 5);
    chk("mid_pending", wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_adr", wr_adr, 0);
    chk("mid_rst_data", wr_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_post_ready", in_ready, 0);
    in_valid = 1'b0;
    wlog.delete();
    start_win(8'd40);
    stream(0);
    chk("mid_restart_adr0", wlog[0].adr, 40);
    chk("mid_restart_adr10", wlog[10].adr, 53);
    chk("mid_restart_count", wlog.size(), 20);
    chk("mid_restart_done", done_count(), 1);

`ifdef WIN_WR_ABORT_EN
    wlog.delete();
    start_win(8'd60);
    n = 0;
    while (m_beats < 7 && n < 50) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      tick();
      n++;
    end
    abort = 1'b1;
    chk("abort_ready", in_ready, 0);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("abort_count", wlog.size(), 7);
    chk("abort_no_done", done_count(), 0);
    chk("abort_busy", busy, 0);
    wlog.delete();
    start_win(8'd5);
    stream(0);
    chk("abort_next_count", wlog.size(), 20);
    chk("abort_next_adr0", wlog[0].adr, 5);
    chk("abort_next_done", done_count(), 1);
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
